// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states, ALU/mux selects.
// The control word is a packed struct that the decode sub-module fills.
package multicycle_control_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_XOR   = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'd0,
        SRCB_FOUR    = 2'd1,
        SRCB_IMM     = 2'd2,
        SRCB_IMM_SH2 = 2'd3
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PC_ALU    = 2'd0,
        PC_ALUOUT = 2'd1,
        PC_JUMP   = 2'd2,
        PC_RSVD   = 2'd3
    } pc_src_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       sign_zero;
        logic       instr_done;
        logic       illegal;
        pc_src_e    pc_source;
        alu_op_e    alu_op;
        alu_src_b_e alu_src_b;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Bus between the multicycle controller and its datapath/memory.
// The datapath side (master) drives Opcode/Zero/MemReady; the controller (slave) drives strobes.
interface multicycle_control_if #(
    parameter int unsigned OPCODE_W = 6
);
    logic [OPCODE_W-1:0] Opcode;
    logic                Zero;
    logic                MemReady;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic       SignZero;
    logic       InstrDone;
    logic       Illegal;
    logic [1:0] PCSource;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcB;
    logic [3:0] State;

    modport master (
        output Opcode, Zero, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               ALUSrcA, RegWrite, RegDst, SignZero, InstrDone, Illegal,
               PCSource, ALUOp, ALUSrcB, State
    );

    modport slave (
        input  Opcode, Zero, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               ALUSrcA, RegWrite, RegDst, SignZero, InstrDone, Illegal,
               PCSource, ALUOp, ALUSrcB, State
    );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational state -> control-word map for the multicycle controller.
// MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN enables the Illegal flag in HALT.
module multicycle_control_decode
    import multicycle_control_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    input  logic   nop_done_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b  = SRCB_IMM_SH2;
                ctrl_o.instr_done = nop_done_i;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_XOR;
                ctrl_o.sign_zero = 1'b1;
            end
            S_I_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.sign_zero  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            S_HALT: begin
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
                ctrl_o.illegal = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: state register + next-state logic; outputs via decode.
// MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN: unknown opcodes trap to HALT instead of running as NOP.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.slave  bus
);

    state_e              state_q, state_d;
    ctrl_t               ctrl;
    logic [OPCODE_W-1:0] opcode;
    logic                is_r, is_lw, is_sw, is_beq, is_xori, is_j, op_known, nop_done;

    assign opcode   = bus.Opcode;
    assign is_r     = (opcode == OPCODE_W'(OP_RTYPE));
    assign is_lw    = (opcode == OPCODE_W'(OP_LW));
    assign is_sw    = (opcode == OPCODE_W'(OP_SW));
    assign is_beq   = (opcode == OPCODE_W'(OP_BEQ));
    assign is_xori  = (opcode == OPCODE_W'(OP_XORI));
    assign is_j     = (opcode == OPCODE_W'(OP_J));
    assign op_known = is_r | is_lw | is_sw | is_beq | is_xori | is_j;

`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    assign nop_done = 1'b0;
`else
    assign nop_done = ~op_known;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
            S_DECODE: begin
                if      (is_r)           state_d = S_EXEC_R;
                else if (is_lw || is_sw) state_d = S_MEM_ADDR;
                else if (is_beq)         state_d = S_BRANCH;
                else if (is_xori)        state_d = S_EXEC_I;
                else if (is_j)           state_d = S_JUMP;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
                else                     state_d = S_HALT;
`else
                else                     state_d = S_FETCH;
`endif
            end
            // Opcode stays stable from the IR, so MEM_ADDR can re-split lw/sw.
            S_MEM_ADDR: state_d = is_lw ? S_MEM_RD : (is_sw ? S_MEM_WR : S_FETCH);
            S_MEM_RD:   if (bus.MemReady) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (bus.MemReady) state_d = S_FETCH;
            S_EXEC_R:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_EXEC_I:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            S_HALT:     state_d = S_HALT;
`else
            S_HALT:     state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    multicycle_control_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (bus.MemReady),
        .nop_done_i  (nop_done),
        .ctrl_o      (ctrl)
    );

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.i_or_d;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.SignZero    = ctrl.sign_zero;
    assign bus.InstrDone   = ctrl.instr_done;
    assign bus.Illegal     = ctrl.illegal;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.State       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control.
// Expected per-cycle control words are expanded from an instruction-level model.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic clk;
    logic rst_n;

    multicycle_control_if #(.OPCODE_W(6)) bus ();

    multicycle_control #(.OPCODE_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
    localparam logic [5:0] T_BEQ = 6'b000100, T_XORI = 6'b001110, T_J = 6'b000010;

    // Bit layout of the observed control word (see sig_now).
    localparam logic [18:0] M_PCW = 19'h40000, M_PWC = 19'h20000, M_IOD = 19'h10000;
    localparam logic [18:0] M_MR  = 19'h08000, M_MW  = 19'h04000, M_IRW = 19'h02000;
    localparam logic [18:0] M_MTR = 19'h01000, M_ASA = 19'h00800, M_RW  = 19'h00400;
    localparam logic [18:0] M_RD  = 19'h00200, M_SZ  = 19'h00100, M_ID  = 19'h00080;
    localparam logic [18:0] M_IL  = 19'h00040;

    function automatic logic [18:0] PS(input int unsigned v); return 19'(v) << 4; endfunction
    function automatic logic [18:0] AO(input int unsigned v); return 19'(v) << 2; endfunction
    function automatic logic [18:0] SB(input int unsigned v); return 19'(v);      endfunction

    typedef struct packed {
        logic [3:0]  st;
        logic        rdy;
        logic [18:0] sig;
    } step_t;

    step_t q[$];
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned cyc    = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s @cyc%0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [18:0] sig_now();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
                bus.SignZero, bus.InstrDone, bus.Illegal, bus.PCSource, bus.ALUOp, bus.ALUSrcB};
    endfunction

    function automatic logic known(input logic [5:0] op);
        return op inside {T_R, T_LW, T_SW, T_BEQ, T_XORI, T_J};
    endfunction

    task automatic push(input state_e st, input logic rdy, input logic [18:0] sig);
        q.push_back('{st: st, rdy: rdy, sig: sig});
    endtask

    // Expand one instruction into its expected cycles; fw/mw are MemReady-low waits.
    task automatic gen_instr(input logic [5:0] op, input int unsigned fw, input int unsigned mw);
        for (int unsigned i = 0; i < fw; i++) push(S_FETCH, 1'b0, M_MR | SB(1));
        push(S_FETCH, 1'b1, M_MR | SB(1) | M_IRW | M_PCW);
        if (!known(op)) begin
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            push(S_DECODE, 1'($urandom), SB(3));
            for (int unsigned i = 0; i < 4; i++) push(S_HALT, 1'($urandom), M_IL);
`else
            push(S_DECODE, 1'($urandom), SB(3) | M_ID);
`endif
            return;
        end
        push(S_DECODE, 1'($urandom), SB(3));
        case (op)
            T_LW: begin
                push(S_MEM_ADDR, 1'($urandom), M_ASA | SB(2));
                for (int unsigned i = 0; i < mw; i++) push(S_MEM_RD, 1'b0, M_MR | M_IOD);
                push(S_MEM_RD, 1'b1, M_MR | M_IOD);
                push(S_MEM_WB, 1'($urandom), M_RW | M_MTR | M_ID);
            end
            T_SW: begin
                push(S_MEM_ADDR, 1'($urandom), M_ASA | SB(2));
                for (int unsigned i = 0; i < mw; i++) push(S_MEM_WR, 1'b0, M_MW | M_IOD);
                push(S_MEM_WR, 1'b1, M_MW | M_IOD | M_ID);
            end
            T_R: begin
                push(S_EXEC_R, 1'($urandom), M_ASA | AO(2) | SB(0));
                push(S_R_WB,   1'($urandom), M_RW | M_RD | M_ID);
            end
            T_XORI: begin
                push(S_EXEC_I, 1'($urandom), M_ASA | SB(2) | AO(3) | M_SZ);
                push(S_I_WB,   1'($urandom), M_RW | M_SZ | M_ID);
            end
            T_BEQ:   push(S_BRANCH, 1'($urandom), M_ASA | AO(1) | M_PWC | PS(1) | M_ID);
            default: push(S_JUMP,   1'($urandom), M_PCW | PS(2) | M_ID);
        endcase
    endtask

    // Entered and left at posedge+1.
    task automatic run_steps(input int unsigned max);
        step_t s;
        for (int unsigned k = 0; k < max && q.size() > 0; k++) begin
            s = q.pop_front();
            bus.MemReady = s.rdy;
            bus.Zero     = 1'($urandom);
            @(negedge clk);
            check("state", 32'(bus.State), 32'(s.st));
            check("ctrl",  32'(sig_now()), 32'(s.sig));
            check("rd_wr_excl", 32'(bus.MemRead & bus.MemWrite), 32'd0);
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Reset asserted mid-cycle; outputs must collapse to FETCH decodes immediately.
    task automatic mid_reset();
        bus.MemReady = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_state", 32'(bus.State), 32'(S_FETCH));
        check("rst_ctrl",  32'(sig_now()), 32'(M_MR | SB(1)));
        @(posedge clk);
        #1;
        check("rst_hold_state", 32'(bus.State), 32'(S_FETCH));
        check("rst_hold_done",  32'(bus.InstrDone), 32'd0);
        rst_n = 1'b1;
        q.delete();
    endtask

    initial begin
        logic [5:0] op;
        rst_n        = 1'b0;
        bus.Opcode   = '0;
        bus.MemReady = 1'b0;
        bus.Zero     = 1'b0;
        #3;
        check("por_state", 32'(bus.State), 32'(S_FETCH));
        check("por_ctrl",  32'(sig_now()), 32'(M_MR | SB(1)));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        bus.Opcode = T_LW;   gen_instr(T_LW, 0, 0);   run_steps(1000);
        bus.Opcode = T_SW;   gen_instr(T_SW, 0, 3);   run_steps(1000);
        bus.Opcode = T_BEQ;  gen_instr(T_BEQ, 0, 0);  run_steps(1000);
        bus.Opcode = T_BEQ;  gen_instr(T_BEQ, 1, 0);  run_steps(1000);
        bus.Opcode = T_R;    gen_instr(T_R, 2, 0);    run_steps(1000);
        bus.Opcode = T_XORI; gen_instr(T_XORI, 0, 0); run_steps(1000);
        bus.Opcode = T_J;    gen_instr(T_J, 0, 0);    run_steps(1000);

        bus.Opcode = 6'b111111;
        gen_instr(6'b111111, 0, 0);
        run_steps(1000);
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        mid_reset();
        check("illegal_cleared", 32'(bus.Illegal), 32'd0);
`else
        check("nop_illegal", 32'(bus.Illegal), 32'd0);
`endif

        // Abort a store that is stalled in MEM_WR.
        bus.Opcode = T_SW;
        gen_instr(T_SW, 0, 8);
        run_steps(5);
        check("pre_rst_memwrite", 32'(bus.MemWrite), 32'd1);
        mid_reset();
        check("post_rst_memwrite", 32'(bus.MemWrite), 32'd0);
        bus.Opcode = T_R; gen_instr(T_R, 2, 0); run_steps(1000);

        for (int unsigned n = 0; n < 150; n++) begin
            case ($urandom_range(0, 6))
                0: op = T_R;
                1: op = T_LW;
                2: op = T_SW;
                3: op = T_BEQ;
                4: op = T_XORI;
                5: op = T_J;
                default: begin
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
                    op = T_R;
`else
                    do op = 6'($urandom); while (known(op));
`endif
                end
            endcase
            bus.Opcode = op;
            gen_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
            run_steps(1000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
